// File: rtl/seg7_scan_display_if.sv
// Signal bundle between the stopwatch counter (master) and the
// multiplexed 7-segment display driver (slave).
interface seg7_scan_display_if;
    logic [3:0] num0;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] num3;
    logic       blank_lz;
    logic       blink_en;
    logic       sep_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output num0, num1, num2, num3, blank_lz, blink_en, sep_en,
        input  an, seg, dp
    );

    modport slave (
        input  num0, num1, num2, num3, blank_lz, blink_en, sep_en,
        output an, seg, dp
    );
endinterface

// File: rtl/seg7_scan_display.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Digits are captured once per frame so a frame never mixes two counts;
// supports leading-zero blanking, a separator dot on digit 2 and blinking.
module seg7_scan_display #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 25000000,
    parameter bit          ACT_LOW   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    seg7_scan_display_if.slave   disp
);

    localparam int unsigned CW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    h0, h1, h2, h3;
    logic [BW-1:0] bcnt;
    logic          phase;

    logic [3:0]    cur;
    logic          cur_blank;
    logic          b1, b2, b3;
    logic [3:0]    an_hi;
    logic [6:0]    seg_hi;
    logic          dp_hi;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = 7'h40;
        endcase
        return r;
    endfunction

    // Slot counter and digit index; index advances on the last cycle of a slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Latch all four digits at the end of the frame (last cycle of digit 3)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h0 <= '0;
            h1 <= '0;
            h2 <= '0;
            h3 <= '0;
        end else if (cnt == CNT_LAST && idx == 2'd3) begin
            h0 <= disp.num0;
            h1 <= disp.num1;
            h2 <= disp.num2;
            h3 <= disp.num3;
        end
    end

    // Free-running blink phase, independent of blink_en
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (bcnt == BLINK_LAST) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    // Active-high next-output computation from the current slot state
    always_comb begin
        b3 = disp.blank_lz && (h3 == 4'd0);
        b2 = b3 && (h2 == 4'd0);
        b1 = b2 && (h1 == 4'd0);
        cur       = h0;
        cur_blank = 1'b0;
        case (idx)
            2'd0: begin cur = h0; cur_blank = 1'b0; end
            2'd1: begin cur = h1; cur_blank = b1;   end
            2'd2: begin cur = h2; cur_blank = b2;   end
            default: begin cur = h3; cur_blank = b3; end
        endcase
        seg_hi = cur_blank ? 7'h00 : dec7(cur);
        an_hi  = '0;
        if (cnt != '0 && !(disp.blink_en && phase))
            an_hi = 4'(4'b0001 << idx);
        dp_hi = (idx == 2'd2) && disp.sep_en && (cnt != '0);
    end

    // Registered outputs, polarity applied here; reset forces all inactive
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp.an  <= {4{ACT_LOW}};
            disp.seg <= {7{ACT_LOW}};
            disp.dp  <= ACT_LOW;
        end else begin
            disp.an  <= an_hi  ^ {4{ACT_LOW}};
            disp.seg <= seg_hi ^ {7{ACT_LOW}};
            disp.dp  <= dp_hi  ^ ACT_LOW;
        end
    end

endmodule
